// File: rtl/fm_pkg.sv
// Shared constants, FSM encodings and fixed-point helpers for the FM demodulation path.
// The quantize/dequantize helpers are also used by the arctan unit.
package fm_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int QUANT_BITS = 10;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAIN  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [PROD_WIDTH-1:0] wide_t;

  function automatic wide_t sext(input sample_t v);
    return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic wide_t quantize(input sample_t v);
    return sext(v) <<< QUANT_BITS;
  endfunction

  function automatic sample_t dequantize(input wide_t v);
    return sample_t'(v >>> QUANT_BITS);
  endfunction

endpackage

// File: rtl/fm_conj_mult.sv
// Combinational complex multiply cur * conj(prev), dequantized back to sample width.
// Truncates without saturation; shared with later demod stages.
module fm_conj_mult
  import fm_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] cur_i,
  input  logic [DATA_WIDTH-1:0] cur_q,
  input  logic [DATA_WIDTH-1:0] prev_i,
  input  logic [DATA_WIDTH-1:0] prev_q,
  output logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);

  wide_t re_s;
  wide_t im_s;

  // Sums are formed at full product width so the shift floors the exact result.
  always_comb begin
    re_s = sext(cur_i) * sext(prev_i) + sext(cur_q) * sext(prev_q);
    im_s = sext(cur_q) * sext(prev_i) - sext(cur_i) * sext(prev_q);
    x    = dequantize(re_s);
    y    = dequantize(im_s);
  end

endmodule

// File: rtl/fm_demod_feeder.sv
// Feeds the arctan unit with cur*conj(prev) for each I/Q sample and scales the
// returned angle by GAIN; one sample in flight, first sample after reset yields 0.
module fm_demod_feeder
  import fm_pkg::*;
#(
  parameter int GAIN = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic [DATA_WIDTH-1:0] in_q,
  output logic                  atan_start,
  output logic [DATA_WIDTH-1:0] atan_x,
  output logic [DATA_WIDTH-1:0] atan_y,
  input  logic                  atan_done,
  input  logic [DATA_WIDTH-1:0] atan_angle,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_demod
);

  localparam sample_t GAIN_S = sample_t'(GAIN);

  logic [2:0]            state_r;
  logic [2:0]            next_state_s;
  logic                  accept_s;
  logic                  in_ready_r;
  logic                  atan_start_r;
  logic                  out_valid_r;
  logic                  first_r;
  logic [DATA_WIDTH-1:0] cur_i_r;
  logic [DATA_WIDTH-1:0] cur_q_r;
  logic [DATA_WIDTH-1:0] prev_i_r;
  logic [DATA_WIDTH-1:0] prev_q_r;
  logic [DATA_WIDTH-1:0] atan_x_r;
  logic [DATA_WIDTH-1:0] atan_y_r;
  logic [DATA_WIDTH-1:0] angle_r;
  logic [DATA_WIDTH-1:0] out_demod_r;
  logic [DATA_WIDTH-1:0] x_s;
  logic [DATA_WIDTH-1:0] y_s;
  wide_t                 gain_prod_s;

  fm_conj_mult u_conj_mult (
    .cur_i  (cur_i_r),
    .cur_q  (cur_q_r),
    .prev_i (prev_i_r),
    .prev_q (prev_q_r),
    .x      (x_s),
    .y      (y_s)
  );

  assign accept_s    = (state_r == S_IDLE) && in_valid && in_ready_r;
  assign gain_prod_s = sext(GAIN_S) * sext(angle_r);

  // Next-state decode; atan_done only matters while waiting on arctan.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:  if (accept_s) next_state_s = S_MULT;  else next_state_s = state_r;
      S_MULT:  if (first_r)  next_state_s = S_OUT;   else next_state_s = S_START;
      S_START: next_state_s = S_WAIT;
      S_WAIT:  if (atan_done) next_state_s = S_GAIN; else next_state_s = state_r;
      S_GAIN:  next_state_s = S_OUT;
      S_OUT:   if (out_ready) next_state_s = S_IDLE; else next_state_s = state_r;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State and handshake flags, registered from the upcoming state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      in_ready_r   <= 1'b0;
      atan_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      in_ready_r   <= (next_state_s == S_IDLE);
      atan_start_r <= (next_state_s == S_START);
      out_valid_r  <= (next_state_s == S_OUT);
    end
  end

  // Sample history, arctan operands and the scaled output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_r     <= 1'b1;
      cur_i_r     <= '0;
      cur_q_r     <= '0;
      prev_i_r    <= '0;
      prev_q_r    <= '0;
      atan_x_r    <= '0;
      atan_y_r    <= '0;
      angle_r     <= '0;
      out_demod_r <= '0;
    end else begin
      if (accept_s) begin
        cur_i_r <= in_i;
        cur_q_r <= in_q;
      end
      if (state_r == S_MULT) begin
        prev_i_r <= cur_i_r;
        prev_q_r <= cur_q_r;
        if (first_r) begin
          first_r     <= 1'b0;
          out_demod_r <= '0;
        end else begin
          atan_x_r <= x_s;
          atan_y_r <= y_s;
        end
      end
      if ((state_r == S_WAIT) && atan_done) begin
        angle_r <= atan_angle;
      end
      if (state_r == S_GAIN) begin
        out_demod_r <= dequantize(gain_prod_s);
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign atan_start = atan_start_r;
  assign atan_x     = atan_x_r;
  assign atan_y     = atan_y_r;
  assign out_valid  = out_valid_r;
  assign out_demod  = out_demod_r;

endmodule

// File: tb/tb_fm_demod_feeder.sv
// Scoreboard bench: two feeders (GAIN 1024 and 512) share stimulus, an arctan
// model answers start pulses, and a monitor checks every accepted demod value.
module tb_fm_demod_feeder;

  localparam int ATAN_LAT = 10;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ang;
  } xy_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
  } dm_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_i;
  logic [31:0] in_q;
  logic        atan_done;
  logic [31:0] atan_angle;
  logic        out_ready;
  logic        model_done;
  logic [31:0] model_ang;
  logic        spur_done;
  logic [31:0] spur_ang;

  logic        in_ready0, in_ready1;
  logic        start0, start1;
  logic [31:0] x0, x1, y0, y1;
  logic        out_valid0, out_valid1;
  logic [31:0] demod0, demod1;

  xy_t exp_xy_q[$];
  dm_t exp_dm_q[$];

  int tests = 0;
  int failed = 0;
  int viol = 0;
  int starts_seen = 0;
  int exp_starts = 0;

  assign atan_done  = model_done | spur_done;
  assign atan_angle = spur_done ? spur_ang : model_ang;

  fm_demod_feeder #(.GAIN(1024)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_i(in_i), .in_q(in_q), .atan_start(start0), .atan_x(x0), .atan_y(y0),
    .atan_done(atan_done), .atan_angle(atan_angle), .out_valid(out_valid0),
    .out_ready(out_ready), .out_demod(demod0)
  );

  fm_demod_feeder #(.GAIN(512)) u_dut_half (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_i(in_i), .in_q(in_q), .atan_start(start1), .atan_x(x1), .atan_y(y1),
    .atan_done(atan_done), .atan_angle(atan_angle), .out_valid(out_valid1),
    .out_ready(out_ready), .out_demod(demod1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: actual=%0d required=%0d", name, $signed(act), $signed(req));
    end
  endtask

  // Arctan model: checks operands at each start, answers ATAN_LAT cycles later.
  initial begin : arctan_model
    xy_t e;
    logic [31:0] ang;
    model_done = 1'b0;
    model_ang  = 32'd0;
    forever begin
      @(negedge clock);
      if (start0) begin
        starts_seen++;
        ang = 32'd0;
        check("start_pair", {31'd0, start1}, 32'd1);
        if (exp_xy_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_start: actual=1 required=0");
        end else begin
          e = exp_xy_q.pop_front();
          ang = e.ang;
          check("atan_x", x0, e.x);
          check("atan_y", y0, e.y);
          check("atan_x_half", x1, e.x);
          check("atan_y_half", y1, e.y);
        end
        @(negedge clock);
        check("start_single_cycle", {31'd0, start0}, 32'd0);
        repeat (ATAN_LAT - 1) @(posedge clock);
        #1;
        model_done = 1'b1;
        model_ang  = ang;
        @(posedge clock);
        #1;
        model_done = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard on every demod handshake.
  initial begin : monitor
    dm_t e;
    forever begin
      @(negedge clock);
      if ((out_valid0 && in_ready0) || (out_valid1 && in_ready1)) viol++;
      if (out_valid0 && out_ready) begin
        if (exp_dm_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_output: actual=%0d required=none", $signed(demod0));
        end else begin
          e = exp_dm_q.pop_front();
          check("out_demod", demod0, e.d0);
          check("out_demod_half", demod1, e.d1);
          check("out_valid_half", {31'd0, out_valid1}, 32'd1);
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clock);
    while (!in_ready0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("accept_timeout", {31'd0, in_ready0}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clock);
    while (!out_valid0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("out_valid_timeout", {31'd0, out_valid0}, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clock);
    while (!(exp_dm_q.size() == 0 && in_ready0) && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", {31'd0, in_ready0}, 32'd1);
  endtask

  task automatic send(input int i, input int q, input bit has_start, input bit has_out,
                      input int ex, input int ey, input int ang, input int d0, input int d1);
    @(posedge clock);
    #1;
    in_i = i;
    in_q = q;
    in_valid = 1'b1;
    if (has_start) begin
      exp_xy_q.push_back('{x: ex, y: ey, ang: ang});
      exp_starts++;
    end
    if (has_out) exp_dm_q.push_back('{d0: d0, d1: d1});
    wait_accept();
    in_valid = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    bit ok;
    int starts_before;
    reset = 1'b0;
    in_valid = 1'b0;
    in_i = 32'd0;
    in_q = 32'd0;
    out_ready = 1'b1;
    spur_done = 1'b0;
    spur_ang = 32'd0;

    @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check("rst_atan_x", x0, 32'd0);
    check("rst_out_demod", demod0, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("in_ready_after_release", {31'd0, in_ready0}, 32'd1);

    // First sample: no arctan, zero output two cycles after acceptance.
    send(1024, 0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("first_lat_cycle1", {31'd0, out_valid0}, 32'd0);
    @(negedge clock);
    check("first_lat_cycle2", {31'd0, out_valid0}, 32'd1);
    wait_drain();

    // Quarter turn; start two cycles after acceptance.
    send(0, 1024, 1'b1, 1'b1, 0, 1024, 1608, 1608, 804);
    @(negedge clock);
    check("start_lat_cycle1", {31'd0, start0}, 32'd0);
    @(negedge clock);
    check("start_lat_cycle2", {31'd0, start0}, 32'd1);
    wait_drain();

    send(1024, 0, 1'b1, 1'b1, 0, -1024, -1608, -1608, -804);
    wait_drain();
    send(-512, 300, 1'b1, 1'b1, -512, 300, 2835, 2835, 1417);
    wait_drain();
    send(3, 5, 1'b1, 1'b1, -1, -4, -7, -7, -4);
    wait_drain();

    // Backpressure with the next sample already waiting.
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    send(0, -1024, 1'b1, 1'b1, -5, -3, 100, 100, 50);
    wait_out_valid();
    @(posedge clock);
    #1;
    in_i = 32'd7;
    in_q = 32'd0;
    in_valid = 1'b1;
    exp_xy_q.push_back('{x: 32'd0, y: 32'd7, ang: 32'd11});
    exp_starts++;
    exp_dm_q.push_back('{d0: 32'd11, d1: 32'd5});
    starts_before = starts_seen;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!out_valid0 || demod0 !== 32'd100 || demod1 !== 32'd50 || in_ready0) ok = 1'b0;
    end
    check("bp_hold_stable", {31'd0, ok}, 32'd1);
    check("bp_no_start", starts_seen, starts_before);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    wait_drain();

    // Spurious done in idle.
    @(posedge clock);
    #1;
    spur_ang = 32'd999;
    spur_done = 1'b1;
    @(posedge clock);
    #1;
    spur_done = 1'b0;
    @(negedge clock);
    check("spur_idle_in_ready", {31'd0, in_ready0}, 32'd1);
    check("spur_idle_out_valid", {31'd0, out_valid0}, 32'd0);
    check("spur_idle_demod", demod0, 32'd11);

    // Spurious done while parked in output.
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    send(1024, 1024, 1'b1, 1'b1, 7, 7, 804, 804, 402);
    wait_out_valid();
    @(posedge clock);
    #1;
    spur_done = 1'b1;
    @(posedge clock);
    #1;
    spur_done = 1'b0;
    @(negedge clock);
    check("spur_out_valid", {31'd0, out_valid0}, 32'd1);
    check("spur_out_demod", demod0, 32'd804);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Reset while waiting on arctan; the stale done arrives afterwards.
    starts_before = starts_seen;
    send(0, 512, 1'b1, 1'b0, 512, 512, 5, 0, 0);
    n = 0;
    while (starts_seen == starts_before && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("midflight_start_seen", starts_seen, starts_before + 1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready0}, 32'd0);
    check("midrst_atan_x", x0, 32'd0);
    check("midrst_atan_y", y0, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid0}, 32'd0);
    check("midrst_out_demod", demod0, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    send(40, 9, 1'b0, 1'b1, 0, 0, 0, 0, 0);
    wait_drain();
    repeat (20) @(negedge clock);

    check("xy_queue_empty", exp_xy_q.size(), 32'd0);
    check("start_count", starts_seen, exp_starts);
    check("ready_valid_overlap", viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
